if_id_stage_buf: RTL and testbench
==================================

Name: if_id_stage_buf

Overview:
- Parametrised IF/ID pipeline stage between the fetch unit and the decoder.
- Replaces the plain IF/ID register with four additions: a valid/ready handshake on both sides, a 2-entry skid buffer so fetch never loses an instruction when decode stalls, flush-to-bubble with a configurable NOP encoding, and saturating stall/flush performance counters.

Parameters:
- PC_W, 64, program counter width.
- INSTR_W, 32, instruction width.
- NOP_INSTR, {INSTR_W{1'b0}}, encoding driven on out_instr when the stage holds no valid entry.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept a beat; combinational, equals (state != TWO).
- in_pc  in  PC_W  PC of the fetched instruction.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode-side entry is valid; registered.
- out_ready  in  1  decode can consume.
- out_pc  out  PC_W  head-entry PC.
- out_instr  out  INSTR_W  head-entry instruction.
- stall  in  1  hazard-unit hold; blocks consumption independent of out_ready.
- flush  in  1  branch/jump redirect; discards all entries.
- stall_cnt  out  CNT_W  cycles with stall=1 and out_valid=1.
- flush_cnt  out  CNT_W  flush events that discarded at least one entry.

Behaviour:

Definitions
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready & ~stall.
- Storage: a head register (out_pc, out_instr) and a skid register (skid_pc, skid_instr).

State machine (EMPTY, ONE, TWO)
- out_valid = (state != EMPTY).
- EMPTY:
  - in_fire -> ONE; head <= in.
  - else stay.
- ONE:
  - in_fire & out_fire -> ONE; head <= in.
  - in_fire & ~out_fire -> TWO; skid <= in, head holds.
  - ~in_fire & out_fire -> EMPTY.
  - else hold.
- TWO (in_ready = 0):
  - out_fire -> ONE; head <= skid.
  - else hold.

Ordering and data rules
- Instructions leave in strict arrival order.
- No combinational path from in_* to out_*.
- Latency is one cycle from in_fire into EMPTY to out_valid.
- Whenever the next state is EMPTY, out_instr <= NOP_INSTR and out_pc holds its last value. Decode therefore always sees a bubble encoding when invalid.
- While stall=1 or out_ready=0, head and skid contents are frozen.

Flush
- flush has priority over every other event in the same cycle.
- Next state is EMPTY and out_instr <= NOP_INSTR.
- Any beat accepted that cycle (in_fire=1) is consumed and discarded, i.e. fetch sees it accepted.
- A simultaneous out_fire still counts as consumed by decode; the stage does not re-present it.
- flush_cnt increments if pre-flush state != EMPTY or in_fire=1.

Counters
- Both counters saturate at all-ones and never wrap.
- stall_cnt increments on every cycle with stall & out_valid.

Reset
- On reset=0, asynchronously and immediately, including mid-operation:
  - state = EMPTY, out_valid = 0, in_ready = 1;
  - out_pc = 0, out_instr = NOP_INSTR;
  - skid registers = 0;
  - stall_cnt = 0, flush_cnt = 0.
- On deassertion, the first accepted beat appears one cycle later.

Test Plan:
1. Streaming:
   - Stimulus: reset release, then in_valid=1 with PCs 0x0,0x4,0x8 and instrs 0x00A00093/0x00B00113/0x00C00193; out_ready=1, stall=0.
   - Required: out_valid rises one cycle after the first beat; the three beats appear in order on consecutive cycles; in_ready stays 1; stall_cnt=0.
2. Skid fill:
   - Stimulus: stall=1 while feeding PCs 0x10, 0x14, 0x18.
   - Required: 0x10 in head, 0x14 in skid, in_ready=0 after two accepts, 0x18 held by fetch.
   - Then stall=0: out shows 0x10, 0x14, 0x18 in consecutive cycles.
   - stall_cnt equals the number of stalled cycles with out_valid=1.
3. Flush with full buffer:
   - Stimulus: from state TWO, assert flush for one cycle with in_valid=0.
   - Required next cycle: out_valid=0, out_instr=NOP_INSTR, in_ready=1, flush_cnt=1.
   - Next accepted beat (PC 0x100) is presented one cycle later.
4. Flush coincident with in_fire and stall:
   - Stimulus: state ONE, stall=1, in_valid=1 (PC 0x20), flush=1.
   - Required: beat 0x20 is accepted and dropped; state EMPTY; flush_cnt increments by 1; 0x20 never appears on out.
5. Counter saturation, CNT_W=4:
   - Stimulus: hold stall=1 with a valid entry for 20 cycles.
   - Required: stall_cnt reaches 0xF and stays 0xF.
6. Async reset mid-operation:
   - Stimulus: state TWO, counters nonzero; drive reset=0 between clock edges.
   - Required, without waiting for clk: out_valid=0, out_instr=NOP_INSTR, out_pc=0, both counters 0, in_ready=1.

Source files
------------

// File: rtl/if_id_stage_buf.sv
// IF/ID pipeline stage: valid/ready handshake on both sides, 2-entry skid buffer,
// flush-to-bubble with a configurable NOP encoding, saturating stall/flush counters.
module if_id_stage_buf #(
  parameter int unsigned              PC_W      = 64,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = {INSTR_W{1'b0}},
  parameter int unsigned              CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               stall,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_fire;
  logic               out_fire;

  assign in_ready = (state != TWO);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;

  // Occupancy FSM with head/skid storage; flush overrides every other event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_instr  <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_instr <= in_instr;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
          end else if (in_fire) begin
            state      <= TWO;
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
          end
        end
        TWO: begin
          if (out_fire) begin
            state     <= ONE;
            out_pc    <= skid_pc;
            out_instr <= skid_instr;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_instr <= NOP_INSTR;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && out_valid && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && ((state != EMPTY) || in_fire) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Bench for if_id_stage_buf: directed scenarios plus randomized traffic against a queue model.
module tb_if_id_stage_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready, stall, flush;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_pc;
  logic [31:0] s_out_instr;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  if_id_stage_buf #(.PC_W(64), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_stage_buf #(.PC_W(64), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_instr(s_out_instr),
    .stall(stall), .flush(flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: an ordered queue of held beats plus unbounded event counts.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       mq[$];
  int          m_stall;
  int          m_flush;
  logic [63:0] m_last_pc;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic logic exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [63:0] exp_pc();
    return (mq.size() > 0) ? mq[0].pc : m_last_pc;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() > 0) ? mq[0].instr : NOP;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall   = 0;
    m_flush   = 0;
    m_last_pc = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return #1 after it.
  task automatic tick(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic st, input logic fl);
    logic  acc, cons;
    beat_t b;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    @(posedge clk);
    acc  = iv && (mq.size() < 2);
    cons = (mq.size() > 0) && ordy && !st;
    if (st && mq.size() > 0) m_stall++;
    if (fl) begin
      if (mq.size() > 0 || acc) m_flush++;
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) begin
        b.pc = pc;
        b.instr = ins;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) m_last_pc = mq[0].pc;
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 1; stall = 0; flush = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_pc !== 64'h0 || out_instr !== NOP) begin
      failures++;
      $display("FAIL reset_data: pc=%h instr=%h required 0/%h", out_pc, out_instr, NOP);
    end
    checks++;
    if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_cnt: stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt);
    end
    @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic test_streaming();
    logic [63:0] pcs[3];
    logic [31:0] ins[3];
    pcs = '{64'h0, 64'h4, 64'h8};
    ins = '{32'h00A00093, 32'h00B00113, 32'h00C00193};
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, pcs[i], ins[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i] || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_beat%0d: v=%b pc=%h instr=%h rdy=%b required 1/%h/%h/1",
                 i, out_valid, out_pc, out_instr, in_ready, pcs[i], ins[i]);
      end
    end
    idle();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h8 || stall_cnt !== 16'h0) begin
      failures++;
      $display("FAIL stream_drain: v=%b instr=%h pc=%h stall_cnt=%0d required 0/%h/8/0",
               out_valid, out_instr, out_pc, stall_cnt, NOP);
    end
  endtask

  task automatic test_skid_fill();
    int base;
    base = m_stall;
    tick(1'b1, 64'h10, 32'h1111_0010, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 64'h14, 32'h1111_0014, 1'b1, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 64'h10 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL skid_full: rdy=%b pc=%h v=%b required 0/10/1", in_ready, out_pc, out_valid);
    end
    tick(1'b1, 64'h18, 32'h1111_0018, 1'b1, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 64'h10 || stall_cnt !== 16'(base + 2)) begin
      failures++;
      $display("FAIL skid_hold: rdy=%b pc=%h stall_cnt=%0d required 0/10/%0d",
               in_ready, out_pc, stall_cnt, base + 2);
    end
    tick(1'b1, 64'h18, 32'h1111_0018, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_pc !== 64'h14 || out_instr !== 32'h1111_0014 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_drain1: pc=%h instr=%h rdy=%b required 14/11110014/1", out_pc, out_instr, in_ready);
    end
    tick(1'b1, 64'h18, 32'h1111_0018, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_pc !== 64'h18 || out_instr !== 32'h1111_0018 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL skid_drain2: pc=%h instr=%h v=%b required 18/11110018/1", out_pc, out_instr, out_valid);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'(base + 2)) begin
      failures++;
      $display("FAIL skid_end: v=%b stall_cnt=%0d required 0/%0d", out_valid, stall_cnt, base + 2);
    end
  endtask

  task automatic test_flush_full();
    int fbase;
    fbase = m_flush;
    tick(1'b1, 64'h30, 32'h2222_0030, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 64'h34, 32'h2222_0034, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1 || flush_cnt !== 16'(fbase + 1)) begin
      failures++;
      $display("FAIL flush_full: v=%b instr=%h rdy=%b flush_cnt=%0d required 0/%h/1/%0d",
               out_valid, out_instr, in_ready, flush_cnt, NOP, fbase + 1);
    end
    tick(1'b1, 64'h100, 32'h3333_0100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== 32'h3333_0100) begin
      failures++;
      $display("FAIL flush_refill: v=%b pc=%h instr=%h required 1/100/33330100", out_valid, out_pc, out_instr);
    end
    idle();
  endtask

  task automatic test_flush_infire();
    int fbase;
    tick(1'b1, 64'h40, 32'h4444_0040, 1'b1, 1'b1, 1'b0);
    fbase = m_flush;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_infire_accept: rdy=%b required 1", in_ready);
    end
    tick(1'b1, 64'h20, 32'h4444_0020, 1'b1, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || flush_cnt !== 16'(fbase + 1)) begin
      failures++;
      $display("FAIL flush_infire: v=%b instr=%h flush_cnt=%0d required 0/%h/%0d",
               out_valid, out_instr, flush_cnt, NOP, fbase + 1);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 64'h40) begin
        failures++;
        $display("FAIL flush_infire_drop%0d: v=%b pc=%h required 0/40", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_saturation();
    tick(1'b1, 64'h50, 32'h5555_0050, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL sat_stall4: cnt=%h required f", s_stall_cnt);
    end
    tick(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'(sat(m_stall, 16))) begin
      failures++;
      $display("FAIL sat_hold: cnt4=%h cnt16=%0d required f/%0d", s_stall_cnt, stall_cnt, sat(m_stall, 16));
    end
    idle();
  endtask

  task automatic test_async_reset();
    tick(1'b1, 64'h60, 32'h6666_0060, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 64'h64, 32'h6666_0064, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0 || out_instr !== NOP) begin
      failures++;
      $display("FAIL async_reset_data: v=%b rdy=%b pc=%h instr=%h required 0/1/0/%h",
               out_valid, in_ready, out_pc, out_instr, NOP);
    end
    checks++;
    if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0 || s_stall_cnt !== 4'h0 || s_flush_cnt !== 4'h0) begin
      failures++;
      $display("FAIL async_reset_cnt: %0d %0d %0d %0d required all 0",
               stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt);
    end
    #1 reset = 1'b1;
    tick(1'b1, 64'h70, 32'h7777_0070, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h70) begin
      failures++;
      $display("FAIL async_reset_first: v=%b pc=%h required 1/70", out_valid, out_pc);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      checks++;
      if (out_valid !== exp_valid() || in_ready !== (mq.size() < 2) ||
          out_pc !== exp_pc() || out_instr !== exp_instr()) begin
        failures++;
        $display("FAIL rand_out[%0d]: v=%b rdy=%b pc=%h instr=%h required %b/%b/%h/%h", i,
                 out_valid, in_ready, out_pc, out_instr, exp_valid(), (mq.size() < 2), exp_pc(), exp_instr());
      end
      checks++;
      if (stall_cnt !== 16'(sat(m_stall, 16)) || flush_cnt !== 16'(sat(m_flush, 16))) begin
        failures++;
        $display("FAIL rand_cnt16[%0d]: stall=%0d flush=%0d required %0d/%0d", i,
                 stall_cnt, flush_cnt, sat(m_stall, 16), sat(m_flush, 16));
      end
      checks++;
      if (s_stall_cnt !== 4'(sat(m_stall, 4)) || s_flush_cnt !== 4'(sat(m_flush, 4)) ||
          s_out_valid !== exp_valid() || s_in_ready !== (mq.size() < 2) ||
          s_out_pc !== exp_pc() || s_out_instr !== exp_instr()) begin
        failures++;
        $display("FAIL rand_sat[%0d]: stall=%0d flush=%0d v=%b pc=%h required %0d/%0d/%b/%h", i,
                 s_stall_cnt, s_flush_cnt, s_out_valid, s_out_pc,
                 sat(m_stall, 4), sat(m_flush, 4), exp_valid(), exp_pc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush_full();
    test_flush_infire();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
